// File: rtl/spatial_encoder_multimod.sv
// Spatial HD encoder: per-modality IM/projection binding, per-bit majority threshold, then 3-way bitwise majority.
// Latency: max(N_CHm)+1 cycles from sample accept to ValidOut_SO when the SRAM never stalls.
// Backpressure: one sample in flight; SRAM stalls freeze the channel walk, ReadyIn_SI holds the result in OUT.
module spatial_encoder_multimod #(
  parameter int HV_DIM = 2000,
  parameter int CH_W   = 8,
  parameter int N_CH0  = 32,
  parameter int N_CH1  = 77,
  parameter int N_CH2  = 105,
  localparam int N_CH_TOT = N_CH0 + N_CH1 + N_CH2,
  localparam int N_MAX    = (N_CH0 > N_CH1) ? ((N_CH0 > N_CH2) ? N_CH0 : N_CH2)
                                            : ((N_CH1 > N_CH2) ? N_CH1 : N_CH2),
  localparam int AW       = (N_MAX > 1) ? $clog2(N_MAX) : 1
) (
  input  logic                         Clk_CI,
  input  logic                         Reset_RI,
  input  logic                         ValidIn_SI,
  output logic                         ReadyOut_SO,
  input  logic [CH_W*N_CH_TOT-1:0]     ChannelsInput_DI,
  output logic [2:0]                   SramReq_SO,
  output logic [AW-1:0]                SramAddr_DO,
  input  logic [2:0]                   SramValid_SI,
  input  logic [3*HV_DIM-1:0]          IM_DI,
  input  logic [3*HV_DIM-1:0]          ProjPos_DI,
  input  logic [3*HV_DIM-1:0]          ProjNeg_DI,
  output logic                         ValidOut_SO,
  input  logic                         ReadyIn_SI,
  output logic [HV_DIM-1:0]            HypervectorOut_DO
);

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            ch_q;
  logic                     done_q;
  logic [2:0]               active, ok;
  logic                     accept, adv, last;
  logic [2:0][HV_DIM-1:0]   hv_m;

  assign accept      = (state_q == IDLE) && ValidIn_SI;
  assign adv         = (state_q == FETCH) && !done_q && (&ok);
  assign last        = (32'(ch_q) == N_MAX - 1);
  assign SramAddr_DO = ch_q;

  // done_q marks the settle cycle after the final channel, so OUT starts one edge later
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q <= IDLE;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ch_q   <= '0;
        done_q <= 1'b0;
      end else if (adv) begin
        ch_q   <= last ? '0 : ch_q + AW'(1);
        done_q <= last;
      end else if (done_q) begin
        done_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ReadyOut_SO = 1'b0;
    ValidOut_SO = 1'b0;
    case (state_q)
      IDLE: begin
        ReadyOut_SO = 1'b1;
        if (ValidIn_SI) state_d = FETCH;
      end
      FETCH: if (done_q) state_d = OUT;
      OUT: begin
        ValidOut_SO = 1'b1;
        if (ReadyIn_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar m = 0; m < 3; m++) begin : g_mod
    localparam int N   = (m == 0) ? N_CH0 : (m == 1) ? N_CH1 : N_CH2;
    localparam int OFF = (m == 0) ? 0 : (m == 1) ? N_CH0 : N_CH0 + N_CH1;
    localparam int CW  = $clog2(N + 1);

    logic [2**AW-1:0] sgn_d, sgn_q;
    logic [CW-1:0]    cnt_q [HV_DIM];
    logic [HV_DIM-1:0] proj, bound, hv;

    // Only the sign of each feature steers the binding, so that is all we keep
    always_comb begin
      sgn_d = '0;
      for (int c = 0; c < N; c++) sgn_d[c] = ChannelsInput_DI[(N_CH_TOT - OFF - c) * CH_W - 1];
    end

    assign active[m]     = (32'(ch_q) < N);
    assign ok[m]         = !active[m] || SramValid_SI[m];
    assign SramReq_SO[m] = (state_q == FETCH) && !done_q && active[m];
    assign proj  = sgn_q[ch_q] ? ProjNeg_DI[m*HV_DIM +: HV_DIM] : ProjPos_DI[m*HV_DIM +: HV_DIM];
    assign bound = IM_DI[m*HV_DIM +: HV_DIM] ^ proj;

    always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
        sgn_q <= '0;
        for (int b = 0; b < HV_DIM; b++) cnt_q[b] <= '0;
      end else if (accept) begin
        sgn_q <= sgn_d;
        for (int b = 0; b < HV_DIM; b++) cnt_q[b] <= '0;
      end else if (adv && active[m]) begin
        for (int b = 0; b < HV_DIM; b++) cnt_q[b] <= cnt_q[b] + CW'(bound[b]);
      end
    end

    // Strict majority: an exact tie on an even channel count resolves to 0
    always_comb begin
      hv = '0;
      for (int b = 0; b < HV_DIM; b++) hv[b] = (32'({cnt_q[b], 1'b0}) > N);
    end

    assign hv_m[m] = hv;
  end

  assign HypervectorOut_DO = (hv_m[0] & hv_m[1]) | (hv_m[0] & hv_m[2]) | (hv_m[1] & hv_m[2]);

endmodule

// File: tb/tb_spatial_encoder_multimod.sv
// Directed bench: default-size encoder plus two tiny configurations for latency, tie and majority corners.
module tb_spatial_encoder_multimod;

  localparam int HV = 2000;
  localparam int NT = 214;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  // default-parameter instance
  logic            d_vin, d_rdy, d_vout, d_rin;
  logic [8*NT-1:0] d_feat;
  logic [2:0]      d_req, d_sv;
  logic [6:0]      d_addr;
  logic [3*HV-1:0] d_im, d_pp, d_pn;
  logic [HV-1:0]   d_hv;

  spatial_encoder_multimod u_def (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(d_vin), .ReadyOut_SO(d_rdy),
    .ChannelsInput_DI(d_feat), .SramReq_SO(d_req), .SramAddr_DO(d_addr),
    .SramValid_SI(d_sv), .IM_DI(d_im), .ProjPos_DI(d_pp), .ProjNeg_DI(d_pn),
    .ValidOut_SO(d_vout), .ReadyIn_SI(d_rin), .HypervectorOut_DO(d_hv)
  );

  // small instances share handshake inputs
  logic        sm_vin, sm_rin;
  logic [2:0]  sm_sv;
  logic        s_rdy, s_vout, t_rdy, t_vout;
  logic [71:0] s_feat;
  logic [31:0] t_feat;
  logic [2:0]  s_req, t_req;
  logic [1:0]  s_addr;
  logic [0:0]  t_addr;
  logic [23:0] s_im, s_pp, s_pn, t_im, t_pp, t_pn;
  logic [7:0]  s_hv, t_hv;

  assign t_pp = {8'h00, 8'h03, (t_addr == 1'b0) ? 8'h03 : 8'h02};

  spatial_encoder_multimod #(.HV_DIM(8), .N_CH0(3), .N_CH1(3), .N_CH2(3)) u_s (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(sm_vin), .ReadyOut_SO(s_rdy),
    .ChannelsInput_DI(s_feat), .SramReq_SO(s_req), .SramAddr_DO(s_addr),
    .SramValid_SI(sm_sv), .IM_DI(s_im), .ProjPos_DI(s_pp), .ProjNeg_DI(s_pn),
    .ValidOut_SO(s_vout), .ReadyIn_SI(sm_rin), .HypervectorOut_DO(s_hv)
  );

  spatial_encoder_multimod #(.HV_DIM(8), .N_CH0(2), .N_CH1(1), .N_CH2(1)) u_t (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(sm_vin), .ReadyOut_SO(t_rdy),
    .ChannelsInput_DI(t_feat), .SramReq_SO(t_req), .SramAddr_DO(t_addr),
    .SramValid_SI(sm_sv), .IM_DI(t_im), .ProjPos_DI(t_pp), .ProjNeg_DI(t_pn),
    .ValidOut_SO(t_vout), .ReadyIn_SI(sm_rin), .HypervectorOut_DO(t_hv)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hv(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got low64 %h want low64 %h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // first p[m] channels of modality m non-negative (alternating 0 / +127), rest negative
  task automatic set_feat(input int p0, input int p1, input int p2);
    int n [3];
    int p [3];
    int g;
    n = '{32, 77, 105};
    p = '{p0, p1, p2};
    g = 0;
    for (int m = 0; m < 3; m++)
      for (int c = 0; c < n[m]; c++) begin
        d_feat[(NT-1-g)*8 +: 8] = (c < p[m]) ? ((c % 2) ? 8'h00 : 8'h7F)
                                             : ((c % 2) ? 8'h80 : 8'hFF);
        g++;
      end
  endtask

  // mode 0 plain, 1 stall bank 2 for 5 cycles at c=40, 2 toggle bank-0 valid after c=31
  task automatic run_d(input int mode, output int lat);
    logic       stalled, held;
    logic [2:0] r32, r77;
    stalled = 1'b0;
    held    = 1'b1;
    r32     = 'x;
    r77     = 'x;
    lat     = 0;
    chk("rdy_before_accept", d_rdy, 1'b1);
    @(negedge clk); d_vin = 1'b1;
    @(posedge clk); #1; d_vin = 1'b0;
    while (d_vout !== 1'b1 && lat < 400) begin
      @(negedge clk);
      d_sv = 3'b111;
      if (lat == 0) chk("req_c0", d_req, 3'b111);
      if (mode == 2 && d_addr == 7'd32) r32 = d_req;
      if (mode == 2 && d_addr == 7'd77) r77 = d_req;
      if (mode == 2 && d_addr >= 7'd32) d_sv[0] = 1'($urandom_range(0, 1));
      if (mode == 1 && d_addr == 7'd40 && !stalled) begin
        stalled = 1'b1;
        for (int k = 0; k < 5; k++) begin
          d_sv[2] = 1'b0;
          @(posedge clk); lat++;
          @(negedge clk);
          held &= (d_addr === 7'd40 && d_req === 3'b110);
        end
        chk("stall_addr_hold", held, 1'b1);
        d_sv = 3'b111;
      end
      @(posedge clk); #1; lat++;
    end
    if (mode == 2) begin
      chk("req_c32", r32, 3'b110);
      chk("req_c77", r77, 3'b100);
    end
  endtask

  task automatic finish_out(input int hold, input logic [HV-1:0] exp);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      ok &= (d_vout === 1'b1 && d_hv === exp && d_rdy === 1'b0);
    end
    if (hold > 0) chk("out_hold_stable", ok, 1'b1);
    @(negedge clk); d_rin = 1'b1;
    @(posedge clk); #1; d_rin = 1'b0;
    chk("out_release_idle", {d_rdy, d_vout}, 2'b10);
  endtask

  task automatic run_small(output int ls, output int lt, output logic [7:0] hs, output logic [7:0] ht);
    ls = -1; lt = -1; hs = 'x; ht = 'x;
    @(negedge clk); sm_vin = 1'b1;
    @(posedge clk); #1; sm_vin = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (s_vout === 1'b1 && ls < 0) begin ls = k; hs = s_hv; end
      if (t_vout === 1'b1 && lt < 0) begin lt = k; ht = t_hv; end
    end
  endtask

  logic [HV-1:0] exp_mix, exp_ones;
  int lat, ls, lt;
  logic [7:0] hs, ht;

  initial begin
    exp_mix  = {(HV/2){2'b10}};
    exp_ones = '1;
    rst = 1'b1;
    d_vin = 1'b0; d_rin = 1'b0; d_sv = 3'b111; d_feat = '0;
    d_im = '0; d_pp = '1; d_pn = {(3*HV/2){2'b10}};
    sm_vin = 1'b0; sm_rin = 1'b1; sm_sv = 3'b111;
    s_im = '0; s_pp = '1; s_pn = '0; t_im = '0; t_pn = '0;
    s_feat = {9{8'h01}}; t_feat = {4{8'h01}};
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // reset/idle state
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_rdy_vout_req", {d_rdy, d_vout, d_req}, 5'b10000);
    end
    chk("idle_addr", d_addr, 7'd0);
    chk_hv("idle_hv", d_hv, '0);
    chk("idle_small", {s_rdy, s_vout, s_req, s_hv}, {5'b10000, 8'h00});

    // tiny configs: (3,3,3) all +1 / all -1, and (2,1,1) tie case
    run_small(ls, lt, hs, ht);
    chk("s_lat_pos", ls, 4);
    chk("s_hv_pos", hs, 8'hFF);
    chk("t_lat", lt, 3);
    chk("t_hv_tie_maj", ht, 8'h02);
    s_feat = {9{8'hFF}}; t_feat = {4{8'hFF}};
    run_small(ls, lt, hs, ht);
    chk("s_lat_neg", ls, 4);
    chk("s_hv_neg", hs, 8'h00);
    chk("t_hv_neg", ht, 8'h00);

    // defaults: thresholds sit on the boundary (16/32 tie, 38/77 low, 53/105 high)
    set_feat(16, 38, 53);
    run_d(0, lat);
    chk("d_lat", lat, 106);
    chk_hv("d_hv_mix", d_hv, exp_mix);
    finish_out(0, exp_mix);

    set_feat(32, 77, 105);
    run_d(0, lat);
    chk("d_lat_pos", lat, 106);
    chk_hv("d_hv_pos", d_hv, exp_ones);
    finish_out(0, exp_ones);

    set_feat(16, 38, 53);
    run_d(1, lat);
    chk("d_lat_stall", lat, 111);
    chk_hv("d_hv_stall", d_hv, exp_mix);
    finish_out(0, exp_mix);

    run_d(2, lat);
    chk("d_lat_toggle", lat, 106);
    chk_hv("d_hv_toggle", d_hv, exp_mix);
    finish_out(0, exp_mix);

    // abort at c=50 by reset, then re-encode the same sample
    set_feat(32, 77, 105);
    @(negedge clk); d_vin = 1'b1;
    @(posedge clk); #1; d_vin = 1'b0;
    lat = 0;
    while (d_addr !== 7'd50 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_reached_c50", d_addr, 7'd50);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", {d_rdy, d_vout, d_req, d_addr}, {5'b10000, 7'd0});
    chk_hv("abort_counters_clear", d_hv, '0);
    @(negedge clk); rst = 1'b0;
    set_feat(16, 38, 53);
    run_d(0, lat);
    chk("d_lat_after_abort", lat, 106);
    chk_hv("d_hv_after_abort", d_hv, exp_mix);
    finish_out(20, exp_mix);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
